// File: rtl/mdu_pkg.sv
// mdu_pkg: shared funct3 codes, FSM state encoding and default XLEN for the multiply-divide unit
package mdu_pkg;
    localparam int XLEN_DEFAULT = 32;
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;
    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DIVSP, S_DONE} state_t;
endpackage

// File: rtl/mdu_bolucu.sv
// mdu_bolucu: radix-2 non-restoring divider core; ports clk, rst, start, abort, dividend/divisor magnitudes in, busy, done, quot, raw signed rem (uncorrected) out
module mdu_bolucu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] quot,
    output logic [XLEN:0]   rem
);
    localparam int CW = $clog2(XLEN) + 1;
    logic [XLEN-1:0] dvs;
    logic [CW-1:0]   cnt;
    logic [XLEN+1:0] r_sh, r_nx;
    assign r_sh = {rem, quot[XLEN-1]};
    assign r_nx = rem[XLEN] ? r_sh + {2'b0, dvs} : r_sh - {2'b0, dvs};
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            busy <= 1'b0;
            done <= 1'b0;
            cnt  <= '0;
            rem  <= '0;
            quot <= '0;
            dvs  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            done <= 1'b0;
            cnt  <= '0;
            rem  <= '0;
            quot <= dividend;
            dvs  <= divisor;
        end else if (busy) begin
            rem  <= r_nx[XLEN:0];
            quot <= {quot[XLEN-2:0], ~r_nx[XLEN+1]};
            cnt  <= cnt + CW'(1);
            if (cnt == CW'(XLEN - 1)) begin
                busy <= 1'b0;
                done <= 1'b1;
                cnt  <= '0;
            end
        end
    end
endmodule

// File: rtl/mdu_iterative.sv
// mdu_iterative: sequential RV M-extension unit; ports clk, rst, in_valid/in_ready, funct3, s1, s2, tag_in, flush, out_valid/out_ready, d3, tag_out; optional divide result cache under MDU_DIV_CACHE_EN
module mdu_iterative
    import mdu_pkg::*;
#(
    parameter int XLEN    = XLEN_DEFAULT,
    parameter int MUL_LAT = 2,
    parameter int TAG_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  s1,
    input  logic [XLEN-1:0]  s2,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  d3,
    output logic [TAG_W-1:0] tag_out
);
    state_t            state;
    logic [1:0]        op;
    logic [1:0]        mcnt;
    logic [XLEN-1:0]   a_q, b_q, min_neg, a_mag, b_mag, bq_mag, quo, rem, r_fix, sp_res, cache_d, div_quo;
    logic [XLEN:0]     div_rem;
    logic [2*XLEN-1:0] ma, mb, prod, mul_res;
    logic              accept, in_sgn, in_sp, hit_in, hit_lat, div_go, div_busy, div_done, sgn, neg_q, neg_r;
    assign accept  = in_valid && in_ready && !flush;
    assign in_sgn  = !funct3[0];
    assign min_neg = {1'b1, {(XLEN-1){1'b0}}};
    assign in_sp   = (s2 == '0) || (in_sgn && s1 == min_neg && &s2);
    assign a_mag   = (in_sgn && s1[XLEN-1]) ? -s1 : s1;
    assign b_mag   = (in_sgn && s2[XLEN-1]) ? -s2 : s2;
    assign div_go  = accept && funct3[2] && !in_sp && !hit_in;
    // rs1 is signed for all but MULHU, rs2 only for MUL/MULH; a 2*XLEN wrap-around product keeps the needed bits exact
    assign ma      = {{XLEN{op != F3_MULHU[1:0] && a_q[XLEN-1]}}, a_q};
    assign mb      = {{XLEN{!op[1] && b_q[XLEN-1]}}, b_q};
    assign prod    = ma * mb;
    if (MUL_LAT == 1) begin : g_comb
        assign mul_res = prod;
    end else begin : g_pipe
        logic [2*XLEN-1:0] pipe [MUL_LAT-1];
        always_ff @(posedge clk) begin
            pipe[0] <= prod;
            for (int i = 1; i < MUL_LAT - 1; i++) pipe[i] <= pipe[i-1];
        end
        assign mul_res = pipe[MUL_LAT-2];
    end
    // non-restoring leaves a negative remainder one divisor short; quotient bits are already final
    assign sgn     = !op[0];
    assign neg_q   = sgn && (a_q[XLEN-1] ^ b_q[XLEN-1]);
    assign neg_r   = sgn && a_q[XLEN-1];
    assign bq_mag  = (sgn && b_q[XLEN-1]) ? -b_q : b_q;
    assign r_fix   = div_rem[XLEN] ? div_rem[XLEN-1:0] + bq_mag : div_rem[XLEN-1:0];
    assign quo     = neg_q ? -div_quo : div_quo;
    assign rem     = neg_r ? -r_fix : r_fix;
    assign sp_res  = (b_q == '0) ? (op[1] ? a_q : '1) : (op[1] ? '0 : a_q);
`ifdef MDU_DIV_CACHE_EN
    logic            c_vld, c_sgn;
    logic [XLEN-1:0] c_s1, c_s2, c_quo, c_rem;
    assign hit_in  = c_vld && s1 == c_s1 && s2 == c_s2 && in_sgn == c_sgn;
    assign hit_lat = c_vld && a_q == c_s1 && b_q == c_s2 && sgn == c_sgn;
    assign cache_d = op[1] ? c_rem : c_quo;
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            c_vld <= 1'b0;
            c_sgn <= 1'b0;
            c_s1  <= '0;
            c_s2  <= '0;
            c_quo <= '0;
            c_rem <= '0;
        end else if (state == S_FIX) begin
            c_vld <= 1'b1;
            c_sgn <= sgn;
            c_s1  <= a_q;
            c_s2  <= b_q;
            c_quo <= quo;
            c_rem <= rem;
        end
    end
`else
    assign hit_in  = 1'b0;
    assign hit_lat = 1'b0;
    assign cache_d = '0;
`endif
    mdu_bolucu #(.XLEN(XLEN)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_go),
        .abort    (flush),
        .dividend (a_mag),
        .divisor  (b_mag),
        .busy     (div_busy),
        .done     (div_done),
        .quot     (div_quo),
        .rem      (div_rem)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            d3        <= '0;
            tag_out   <= '0;
            op        <= '0;
            a_q       <= '0;
            b_q       <= '0;
            mcnt      <= '0;
        end else if (flush) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    state    <= !funct3[2] ? S_MUL : (in_sp || hit_in) ? S_DIVSP : S_DIV;
                    in_ready <= 1'b0;
                    op       <= funct3[1:0];
                    a_q      <= s1;
                    b_q      <= s2;
                    tag_out  <= tag_in;
                    mcnt     <= '0;
                end
                S_MUL: begin
                    mcnt <= mcnt + 2'd1;
                    if (mcnt == 2'(MUL_LAT - 1)) begin
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                        d3        <= (op == F3_MUL[1:0]) ? mul_res[XLEN-1:0] : mul_res[2*XLEN-1:XLEN];
                    end
                end
                S_DIV: if (div_done && !div_busy) state <= S_FIX;
                S_FIX: begin
                    state     <= S_DONE;
                    out_valid <= 1'b1;
                    d3        <= op[1] ? rem : quo;
                end
                S_DIVSP: begin
                    state     <= S_DONE;
                    out_valid <= 1'b1;
                    d3        <= hit_lat ? cache_d : sp_res;
                end
                S_DONE: if (out_ready) begin
                    state     <= S_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_iterative.sv
// tb_mdu_iterative: directed self-checking bench for mdu_iterative (XLEN=32, MUL_LAT=2, TAG_W=5)
module tb_mdu_iterative;
`ifdef MDU_DIV_CACHE_EN
    localparam int HL = 1;
`else
    localparam int HL = 34;
`endif
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
    logic [2:0]  funct3;
    logic [31:0] s1, s2, d3;
    logic [4:0]  tag_in, tag_out;
    int          n_chk = 0, n_pass = 0;
    logic [4:0]  tag_n = 5'd1;
    always #5 clk = ~clk;
    mdu_iterative #(.XLEN(32), .MUL_LAT(2), .TAG_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct3    (funct3),
        .s1        (s1),
        .s2        (s2),
        .tag_in    (tag_in),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d3        (d3),
        .tag_out   (tag_out)
    );
    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, output int lat);
        in_valid = 1'b1;
        funct3   = f3;
        s1       = a;
        s2       = b;
        tag_in   = tag_n;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask
    task automatic run(input string nm, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int exp_lat);
        int lat;
        do_op(f3, a, b, lat);
        check(nm, d3, exp);
        check({nm, " lat"}, lat, exp_lat);
        check({nm, " tag"}, tag_out, tag_n);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({nm, " rdy"}, in_ready, 1);
        tag_n = tag_n + 5'd3;
    endtask
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int   lat;
        logic seen;
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        funct3 = '0; s1 = '0; s2 = '0; tag_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst in_ready", in_ready, 1);
        check("rst out_valid", out_valid, 0);
        check("rst d3", d3, 0);
        check("rst tag_out", tag_out, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        run("mulh min*min",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2);
        run("mulhsu -1*max",  3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
        run("mul -1*-1",      3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 2);
        run("mulhu max*max",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
        run("div ovf",        3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run("rem ovf",        3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
        run("divu 7/0",       3'b101, 32'd7,         32'd0,         32'hFFFF_FFFF, 1);
        run("remu 7/0",       3'b111, 32'd7,         32'd0,         32'd7,         1);
        run("div -5/0",       3'b100, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 1);
        run("rem -5/0",       3'b110, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1);
        run("div -7/2",       3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34);
        run("rem -7/2",       3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, HL);
        run("div 7/-2",       3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
        run("rem 7/-2",       3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1,         HL);
        run("divu 100/7",     3'b101, 32'd100,       32'd7,         32'd14,        34);
        run("remu 100/7",     3'b111, 32'd100,       32'd7,         32'd2,         HL);
        run("divu max/1",     3'b101, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 34);
        do_op(3'b000, 32'd6, 32'd7, lat);
        check("bp d3", d3, 42);
        check("bp lat", lat, 2);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp hold d3", d3, 42);
            check("bp hold tag", tag_out, tag_n);
            check("bp hold in_ready", in_ready, 0);
            check("bp hold out_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp release in_ready", in_ready, 1);
        check("bp release out_valid", out_valid, 0);
        tag_n = tag_n + 5'd3;
        in_valid = 1'b1; funct3 = 3'b101; s1 = 32'd1000; s2 = 32'd3; tag_in = tag_n;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("flush busy in_ready", in_ready, 0);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1; in_valid = 1'b1; funct3 = 3'b000; s1 = 32'd5; s2 = 32'd5;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush out_valid", out_valid, 0);
        check("flush in_ready", in_ready, 1);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            seen = seen | out_valid;
        end
        check("flush no result", seen, 0);
        run("mul 3x4",        3'b000, 32'd3,         32'd4,         32'd12,        2);
        run("divu after flush", 3'b101, 32'd1000,    32'd3,         32'd333,       34);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mdu_iterative.md
Name: mdu_iterative

Overview:
- Sequential RV32M/RV64M multiply-divide unit with valid/ready handshakes on the input and result sides.
- Generalises the combinational MDU to parametrised XLEN and a pipelined multiplier of selectable latency.
- Division is a radix-2 iterative non-restoring divider with full RISC-V corner-case handling, including signed overflow.
- Sits beside the ALU in the execute stage; a tag travels with each operation so writeback can match the result to its rd.

Parameters:
- XLEN, 32, operand/result width (32 or 64).
- MUL_LAT, 2, multiply latency in cycles from accept to out_valid (1..4).
- TAG_W, 5, width of the pass-through tag.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept a request.
- funct3  in  3  M-extension funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- s1  in  XLEN  rs1 operand.
- s2  in  XLEN  rs2 operand.
- tag_in  in  TAG_W  opaque tag.
- flush  in  1  abort the in-flight operation.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- d3  out  XLEN  result.
- tag_out  out  TAG_W  tag of d3.

Behaviour:
- Reset: state IDLE; in_ready=1, out_valid=0, d3=0, tag_out=0. All internal operand registers are cleared.
- Single operation in flight. in_ready=1 only in IDLE. Accept occurs on an edge where in_valid&&in_ready; operands, funct3 and tag are latched at that edge.
- States:
  - IDLE: on accept, go to MUL (funct3[2]=0), DIVSP (special divide) or DIV.
  - MUL: MUL_LAT-1 pipeline stages, then DONE.
  - DIV: XLEN iterations, then FIX.
  - FIX: one cycle for remainder correction and sign restore, then DONE.
  - DIVSP: one cycle, then DONE.
  - DONE: out_valid=1; d3 and tag_out are held stable until out_ready; on out_ready go to IDLE.
- Latency, counted from the accept edge to the first out_valid cycle:
  - multiply: MUL_LAT;
  - divide special case: 1;
  - normal divide: XLEN+2.
- Multiply:
  - Form a 2*XLEN product from operands extended by 1 bit (signed×signed, signed×unsigned where rs1 is signed, unsigned×unsigned).
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
- Divide:
  - Operate on magnitudes; quotient sign = sign(s1)^sign(s2) for signed ops; remainder sign = sign(s1).
  - Divide by zero: quotient is all ones (DIV and DIVU); remainder = s1 (REM and REMU).
  - Signed overflow (s1 = most-negative, s2 = all ones): DIV returns s1; REM returns 0.
  - Both special cases take the DIVSP path.
- Step counter is clog2(XLEN)+1 bits; it wraps only through reset or completion.
- flush: from any state, the next state is IDLE and out_valid drops the following cycle. A result pending in DONE is discarded. flush has priority over out_ready and over a same-cycle accept (no accept when flush=1).
- rst mid-operation: identical to the reset state above; no result is produced.
- d3 does not change while out_valid=1 && !out_ready.
- Back-to-back: DONE→IDLE takes one cycle, so the next accept is at the earliest one cycle after out_ready.

Optional Feature:
- MDU_DIV_CACHE_EN defined:
  - Store the last completed normal divide's s1, s2, signedness, quotient and remainder.
  - A new DIV/REM (or DIVU/REMU) with matching operands and signedness goes IDLE→DONE with latency 1.
  - The cache is invalidated by rst, by flush, and by any aborted divide.
- Undefined: no cache registers; every normal divide takes XLEN+2 cycles.

Decomposition:
- Shared header (alongside the existing constant definitions): funct3 codes, state encodings, XLEN default.
- Sub-module mdu_bolucu: iterative divider core (start/busy/done, magnitude inputs, quotient/remainder outputs).
- Multiply pipeline and the FSM live in the top module.

Test Plan:
- MULH with s1=s2=0x80000000, XLEN=32, MUL_LAT=2 → d3=0x40000000, out_valid on the 2nd cycle after accept, tag echoed.
- MULHSU with s1=0xFFFFFFFF, s2=0xFFFFFFFF → d3=0xFFFFFFFF; MUL with the same operands → d3=0x00000001.
- Divide corner cases:
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0, each at latency 1.
  - DIVU 7/0 → 0xFFFFFFFF and REMU 7/0 → 7.
- DIV 0xFFFFFFF9 (-7) / 2 → 0xFFFFFFFD at latency 34; REM → 0xFFFFFFFF. With MDU_DIV_CACHE_EN, a REM issued right after the DIV → latency 1.
- Backpressure: out_ready held low 5 cycles after out_valid → d3/tag_out stable, in_ready=0; out_ready=1 → in_ready=1 next cycle.
- flush 10 cycles into a DIVU, with in_valid also high → no out_valid; in_ready=1 the next cycle; the following MUL 3×4 returns 12.
